div_pipe_unit: RTL

Fully pipelined, parametrised integer divider that accepts one division per clock and returns quotient, remainder and a per-operation divide-by-zero flag after a fixed latency. It succeeds the single-operation divider in the arithmetic datapath: selectable signed or unsigned mode per operation, a valid/ready handshake on both sides with backpressure, and a tag that travels with each operation. It sits between the operand-issue logic and the writeback buffer.

---
 rtl/div_pipe_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/div_pipe_unit.sv
// Fully pipelined signed/unsigned integer divider: one operation per clock, fixed latency.
// Entry slot takes magnitudes, STAGES slots run restoring division, output slot restores signs.
module div_pipe_unit #(
    parameter int N      = 16,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_q,
    output logic [N-1:0]     out_r,
    output logic             out_div0,
    output logic [TAG_W-1:0] out_tag
);
    localparam int BPS = N / STAGES;
    localparam int L   = STAGES - 1;

    // Two's-complement negate; the magnitude of -2^(N-1) maps onto itself as unsigned 2^(N-1).
    function automatic logic [N-1:0] negate_if(input logic [N-1:0] x, input logic neg);
        logic signed [N-1:0] sx;
        sx = signed'(x);
        return neg ? $unsigned(-sx) : x;
    endfunction

    // BPS restoring steps; quo shifts dividend bits out at the top and quotient bits in at the bottom.
    function automatic logic [2*N:0] div_step(input logic [N:0] rem_in, input logic [N-1:0] quo_in,
                                              input logic [N-1:0] dvs);
        logic [N:0]   rem;
        logic [N-1:0] quo;
        rem = rem_in;
        quo = quo_in;
        for (int i = 0; i < BPS; i++) begin
            rem = {rem[N-1:0], quo[N-1]};
            quo = {quo[N-2:0], 1'b0};
            if (rem >= {1'b0, dvs}) begin
                rem    = rem - {1'b0, dvs};
                quo[0] = 1'b1;
            end
        end
        return {rem, quo};
    endfunction

    logic             stall, advance, sa_in, sb_in;
    logic             vld_p0, nq_p0, nr_p0, d0_p0;
    logic [N-1:0]     quo_p0, dvs_p0;
    logic [TAG_W-1:0] tag_p0;

    logic             vld_pc [STAGES];
    logic             nq_pc  [STAGES];
    logic             nr_pc  [STAGES];
    logic             d0_pc  [STAGES];
    logic [N:0]       rem_pc [STAGES];
    logic [N-1:0]     quo_pc [STAGES];
    logic [N-1:0]     dvs_pc [STAGES];
    logic [TAG_W-1:0] tag_pc [STAGES];

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;
    assign sa_in    = in_signed && in_a[N-1];
    assign sb_in    = in_signed && in_b[N-1];

    // Entry slot: magnitudes, sign decisions, div0 and tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            quo_p0 <= negate_if(in_a, sa_in);
            dvs_p0 <= negate_if(in_b, sb_in);
            nq_p0  <= sa_in ^ sb_in;
            nr_p0  <= sa_in;
            d0_p0  <= (in_b == '0);
            tag_p0 <= in_tag;
        end
    end

    // Compute slots: slot k resolves quotient bits N-1-k*BPS down to N-(k+1)*BPS
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [2*N:0]     step;
        logic             vld_src, nq_src, nr_src, d0_src;
        logic [N-1:0]     dvs_src;
        logic [TAG_W-1:0] tag_src;

        if (k == 0) begin : g_first
            assign step    = div_step('0, quo_p0, dvs_p0);
            assign vld_src = vld_p0;
            assign nq_src  = nq_p0;
            assign nr_src  = nr_p0;
            assign d0_src  = d0_p0;
            assign dvs_src = dvs_p0;
            assign tag_src = tag_p0;
        end else begin : g_next
            assign step    = div_step(rem_pc[k-1], quo_pc[k-1], dvs_pc[k-1]);
            assign vld_src = vld_pc[k-1];
            assign nq_src  = nq_pc[k-1];
            assign nr_src  = nr_pc[k-1];
            assign d0_src  = d0_pc[k-1];
            assign dvs_src = dvs_pc[k-1];
            assign tag_src = tag_pc[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pc[k] <= 1'b0;
            end else if (advance) begin
                vld_pc[k] <= vld_src;
            end
        end

        always_ff @(posedge clk) begin
            if (advance) begin
                rem_pc[k] <= step[2*N:N];
                quo_pc[k] <= step[N-1:0];
                dvs_pc[k] <= dvs_src;
                nq_pc[k]  <= nq_src;
                nr_pc[k]  <= nr_src;
                d0_pc[k]  <= d0_src;
                tag_pc[k] <= tag_src;
            end
        end
    end

    // Output slot: sign fix-up, div0 forces a zero quotient (remainder already equals in_a)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_div0  <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= vld_pc[L];
            if (vld_pc[L]) begin
                out_q    <= d0_pc[L] ? '0 : negate_if(quo_pc[L], nq_pc[L]);
                out_r    <= negate_if(rem_pc[L][N-1:0], nr_pc[L]);
                out_div0 <= d0_pc[L];
                out_tag  <= tag_pc[L];
            end
        end
    end

endmodule
